// File: rtl/pe_pkg.sv
// Shared definitions for the PE datapath stages.
//  - state_t: partial-sum accumulator control states
//  - *_DEF:   default term, accumulator and job-length widths
package pe_pkg;

  localparam int unsigned IN_W_DEF  = 8;
  localparam int unsigned ACC_W_DEF = 20;
  localparam int unsigned LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pe_sat_add.sv
// Unsigned saturating add of a narrow term into a wide accumulator.
// Ports:
//  acc  in  ACC_W  current accumulator value
//  term in  IN_W   term to add (zero-extended)
//  sum  out ACC_W  acc + term, clamped at 2^ACC_W-1
//  ovf  out 1      the true sum exceeded 2^ACC_W-1
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  term,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam int unsigned FULL_W = ACC_W + 1;

  logic [FULL_W-1:0] full;

  // Carry out of the full-width sum selects the clamp value.
  always_comb begin
    full = {1'b0, acc} + FULL_W'(term);
    ovf  = full[ACC_W];
    sum  = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];
  end

endmodule

// File: rtl/pe_psum_accum.sv
// Partial-sum accumulator downstream of the PE adder stage. Sums cfg_len
// terms per job into a saturating accumulator and presents each finished
// sum on a one-deep valid/ready output slot.
// Ports:
//  clk, rst          clock; synchronous active-high reset
//  start, cfg_len    begin a job of cfg_len terms (honoured in IDLE only)
//  in_valid, in_data incoming term stream
//  in_ready          a term is accepted this cycle if in_valid
//  out_valid/ready   result handshake
//  out_data, out_sat finished sum and its sticky saturation flag
//  busy              controller is not IDLE
//  err_spur          pulse: a term was offered while in_ready was low
module pe_psum_accum
  import pe_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic             busy,
  output logic             err_spur
);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic              out_valid_d;
  logic [ACC_W-1:0]  out_data_d;
  logic              out_sat_d;
  logic              err_spur_d;
  logic              slot_free;
  logic [ACC_W-1:0]  add_sum;
  logic              add_ovf;

  pe_sat_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc  (acc_q),
    .term (in_data),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  // Slot can take a new result if empty or being emptied this cycle.
  assign slot_free = !out_valid || out_ready;

  // Next-state, accumulator and output-slot logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_sat_d   = out_sat;
    err_spur_d  = in_valid && !in_ready;

    // Consumption; any load below overrides it.
    if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            acc_d   = '0;
            sat_d   = 1'b0;
            cnt_d   = cfg_len;
            state_d = ACCUM;
          end else if (slot_free) begin
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_sat_d   = 1'b0;
          end else begin
            // Empty job parks a zero result in acc until the slot frees.
            acc_d   = '0;
            sat_d   = 1'b0;
            state_d = DRAIN;
          end
        end
      end

      ACCUM: begin
        if (in_valid) begin
          acc_d = add_sum;
          sat_d = sat_q || add_ovf;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            if (slot_free) begin
              out_valid_d = 1'b1;
              out_data_d  = add_sum;
              out_sat_d   = sat_q || add_ovf;
              state_d     = IDLE;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end

      DRAIN: begin
        if (out_ready) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q;
          out_sat_d   = sat_q;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      err_spur  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_sat   <= out_sat_d;
      err_spur  <= err_spur_d;
    end
  end

endmodule

// File: tb/tb_pe_psum_accum.sv
// Bench for pe_psum_accum: two instances (ACC_W=20 and ACC_W=10) share the
// same stimulus; table vectors, hand-written corner sequences, then a
// randomized run against a queue-based result model.
module tb_pe_psum_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] cfg_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic        a_in_ready, a_out_valid, a_out_sat, a_busy, a_err_spur;
  logic [19:0] a_out_data;
  logic        b_in_ready, b_out_valid, b_out_sat, b_busy, b_err_spur;
  logic [9:0]  b_out_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_psum_accum #(.IN_W(8), .ACC_W(20), .LEN_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_sat(a_out_sat), .busy(a_busy), .err_spur(a_err_spur)
  );

  pe_psum_accum #(.IN_W(8), .ACC_W(10), .LEN_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_sat(b_out_sat), .busy(b_busy), .err_spur(b_err_spur)
  );

  typedef struct {
    int unsigned len;
    int unsigned terms[5];
    int unsigned exp_a;
    bit          sat_a;
    int unsigned exp_b;
    bit          sat_b;
  } vec_t;

  vec_t vq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned clamp(input int unsigned s, input int unsigned w);
    int unsigned mx;
    mx = (32'd1 << w) - 32'd1;
    return (s > mx) ? mx : s;
  endfunction

  // Result present on both instances for a job whose true sum is s.
  task automatic chk_out(input string nm, input int unsigned s);
    chk({nm, "_a_valid"}, a_out_valid, 1);
    chk({nm, "_a_data"},  a_out_data,  clamp(s, 20));
    chk({nm, "_a_sat"},   a_out_sat,   s > 32'hF_FFFF);
    chk({nm, "_b_valid"}, b_out_valid, 1);
    chk({nm, "_b_data"},  b_out_data,  clamp(s, 10));
    chk({nm, "_b_sat"},   b_out_sat,   s > 32'd1023);
  endtask

  task automatic add_vec(input int unsigned len, input int unsigned t0, input int unsigned t1,
                         input int unsigned t2, input int unsigned t3, input int unsigned t4,
                         input int unsigned ea, input bit sa, input int unsigned eb, input bit sb);
    vec_t v;
    v.len = len;
    v.terms[0] = t0; v.terms[1] = t1; v.terms[2] = t2; v.terms[3] = t3; v.terms[4] = t4;
    v.exp_a = ea; v.sat_a = sa; v.exp_b = eb; v.sat_b = sb;
    vq.push_back(v);
  endtask

  // Single-term job with out_ready high; leaves the result consumed.
  task automatic job1(input string nm, input int unsigned t);
    start = 1'b1; cfg_len = 8'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'(t);
    tick();
    in_valid = 1'b0;
    chk_out(nm, t);
    tick();
  endtask

  initial begin
    int unsigned q[$];
    int unsigned rem;
    int unsigned run;
    bit          spur_prev;
    bit          want_busy;

    rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", a_out_valid, 0);
    chk("rst_data",  a_out_data,  0);
    chk("rst_sat",   a_out_sat,   0);
    chk("rst_busy",  a_busy,      0);
    chk("rst_ready", a_in_ready,  0);
    chk("rst_spur",  a_err_spur,  0);
    rst = 1'b0;
    tick();

    // Back-to-back jobs, out_ready high throughout.
    add_vec(4, 10, 20, 30, 40, 0,       100,  0, 100,  0);
    add_vec(5, 255, 255, 255, 255, 255, 1275, 0, 1023, 1);
    add_vec(1, 3, 0, 0, 0, 0,           3,    0, 3,    0);
    add_vec(3, 255, 255, 255, 0, 0,     765,  0, 765,  0);
    add_vec(5, 255, 255, 255, 255, 4,   1024, 0, 1023, 1);
    add_vec(2, 0, 0, 0, 0, 0,           0,    0, 0,    0);
    add_vec(5, 200, 200, 200, 200, 223, 1023, 0, 1023, 0);

    foreach (vq[k]) begin
      start = 1'b1; cfg_len = 8'(vq[k].len);
      tick();
      start = 1'b0;
      chk($sformatf("v%0d_in_ready", k), a_in_ready, 1);
      for (int i = 0; i < int'(vq[k].len); i++) begin
        in_valid = 1'b1; in_data = 8'(vq[k].terms[i]);
        tick();
        if (i < int'(vq[k].len) - 1) chk($sformatf("v%0d_early_valid", k), a_out_valid, 0);
      end
      in_valid = 1'b0;
      chk($sformatf("v%0d_a_valid", k), a_out_valid, 1);
      chk($sformatf("v%0d_a_data", k),  a_out_data,  vq[k].exp_a);
      chk($sformatf("v%0d_a_sat", k),   a_out_sat,   vq[k].sat_a);
      chk($sformatf("v%0d_b_valid", k), b_out_valid, 1);
      chk($sformatf("v%0d_b_data", k),  b_out_data,  vq[k].exp_b);
      chk($sformatf("v%0d_b_sat", k),   b_out_sat,   vq[k].sat_b);
      chk($sformatf("v%0d_idle", k),    a_busy,      0);
    end
    tick();

    // Back-pressure: second result parks in DRAIN, then both drain in order.
    out_ready = 1'b0;
    start = 1'b1; cfg_len = 8'd2;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd1;
    tick();
    in_data = 8'd2;
    tick();
    in_valid = 1'b0;
    chk_out("bp_first", 3);
    start = 1'b1; cfg_len = 8'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd7;
    tick();
    in_valid = 1'b0;
    chk_out("bp_hold", 3);
    chk("bp_drain_ready", a_in_ready, 0);
    chk("bp_drain_busy",  a_busy,     1);
    start = 1'b1; cfg_len = 8'd1;
    tick();
    start = 1'b0;
    chk_out("bp_hold2", 3);
    chk("bp_start_ignored", a_busy, 1);
    out_ready = 1'b1;
    tick();
    chk_out("bp_second", 7);
    chk("bp_idle", a_busy, 0);
    tick();
    chk("bp_empty", a_out_valid, 0);
    chk("bp_no_job", a_in_ready, 0);

    // Zero-length job.
    start = 1'b1; cfg_len = 8'd0;
    tick();
    start = 1'b0;
    chk_out("len0", 0);
    chk("len0_busy", a_busy, 0);
    chk("len0_ready", a_in_ready, 0);
    tick();
    chk("len0_empty", a_out_valid, 0);

    // Reset mid-job.
    start = 1'b1; cfg_len = 8'd8;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd50;
    tick(); tick(); tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", a_out_valid, 0);
    chk("midrst_busy",  a_busy,      0);
    job1("after_rst", 5);

    // Spurious term in IDLE.
    in_valid = 1'b1; in_data = 8'd9;
    tick();
    in_valid = 1'b0;
    chk("spur_a", a_err_spur, 1);
    chk("spur_b", b_err_spur, 1);
    tick();
    chk("spur_off", a_err_spur, 0);
    job1("after_spur", 2);

    // Randomized run against a queue of outstanding results.
    rem = 0; run = 0; spur_prev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      want_busy = (rem > 0) || (q.size() == 2);
      chk("rnd_a_valid", a_out_valid, q.size() > 0);
      chk("rnd_b_valid", b_out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("rnd_a_data", a_out_data, clamp(q[0], 20));
        chk("rnd_a_sat",  a_out_sat,  q[0] > 32'hF_FFFF);
        chk("rnd_b_data", b_out_data, clamp(q[0], 10));
        chk("rnd_b_sat",  b_out_sat,  q[0] > 32'd1023);
      end
      chk("rnd_a_in_ready", a_in_ready, rem > 0);
      chk("rnd_b_in_ready", b_in_ready, rem > 0);
      chk("rnd_a_busy", a_busy, want_busy);
      chk("rnd_b_busy", b_busy, want_busy);
      chk("rnd_a_spur", a_err_spur, spur_prev);

      out_ready = ($urandom_range(0, 3) != 0);
      start     = (rem == 0) && (q.size() < 2) && ($urandom_range(0, 2) == 0);
      cfg_len   = 8'($urandom_range(0, 6));
      if (rem > 0) in_valid = ($urandom_range(0, 4) != 0);
      else         in_valid = ($urandom_range(0, 15) == 0);
      in_data   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(180, 255))
                                              : 8'($urandom_range(0, 255));

      spur_prev = in_valid && (rem == 0);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (rem > 0) begin
        if (in_valid) begin
          run = run + in_data;
          rem = rem - 1;
          if (rem == 0) q.push_back(run);
        end
      end else if (start) begin
        if (cfg_len == 8'd0) q.push_back(0);
        else begin
          rem = cfg_len;
          run = 0;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
